// File: rtl/mfp_7seg_pkg.sv
// rtl/mfp_7seg_pkg.sv - shared types and constants for the 7-segment scanner
// Contents: fsm_t slot phase enum, HEX_SEG active-low glyph table {g,f,e,d,c,b,a},
// SEG_OFF all-segments-dark pattern.
package mfp_7seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } fsm_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n (LSB first) is the active-low glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/mfp_hex_to_7seg.sv
// rtl/mfp_hex_to_7seg.sv - combinational hex nibble to active-low 7-segment decoder
// Ports: hex (in, 4) nibble to show; seg (out, 7) active-low {g,f,e,d,c,b,a}.
module mfp_hex_to_7seg
  import mfp_7seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/mfp_7seg_scanner.sv
// rtl/mfp_7seg_scanner.sv - time-multiplexed common-anode 8-digit 7-segment scanner
// Ports: clk, rst (sync active-high); value (4*DIGITS) hex digits, digit 0 in bits 3:0;
// digit_en / dp (DIGITS) per-digit enable and decimal point; seg_n (7), dp_n, an_n (DIGITS)
// active-low registered pin drives; frame_done one-cycle pulse at end of the last slot.
// Optional: MFP_7SEG_LEADING_ZERO_BLANK_EN darkens digits above the most significant
// non-zero nibble of the captured value (digit 0 always shown, subject to digit_en).
module mfp_7seg_scanner
  import mfp_7seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   digit_en,
  input  logic [DIGITS-1:0]   dp,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an_n,
  output logic                frame_done
);

  localparam int   CW        = $clog2(SLOT_CYCLES);
  localparam int   IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   BLANK_END = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
  // With no blank interval the scanner lives permanently in DRIVE.
  localparam fsm_t RST_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  fsm_t                state, state_nx;
  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_en;
  logic [DIGITS-1:0]   sh_dp;

  logic                slot_end, frame_end;
  logic [4*DIGITS-1:0] shifted;
  logic [3:0]          nib;
  logic [6:0]          seg_dec;
  logic                visible;
  logic [DIGITS-1:0]   an_nx;
  logic [6:0]          seg_nx;
  logic                dp_nx;

  assign slot_end  = (cnt == CW'(SLOT_CYCLES - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

  always_comb begin
    state_nx = state;
    if (BLANK_CYCLES == 0) begin
      state_nx = DRIVE;
    end else if (slot_end) begin
      state_nx = BLANK;
    end else if (state == BLANK && cnt == CW'(BLANK_END)) begin
      state_nx = DRIVE;
    end
  end

`ifdef MFP_7SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] sh_msd, msd_nx;

  // Highest non-zero nibble of the incoming word, evaluated at capture time.
  always_comb begin
    msd_nx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] != 4'h0) msd_nx = IW'(i);
    end
  end

  assign visible = (idx <= sh_msd);
`else
  assign visible = 1'b1;
`endif

  assign shifted = sh_value >> {idx, 2'b00};
  assign nib     = shifted[3:0];

  mfp_hex_to_7seg u_dec (
    .hex (nib),
    .seg (seg_dec)
  );

  always_comb begin
    an_nx  = '1;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    if (state == DRIVE) begin
      if (sh_en[idx] && visible) begin
        an_nx[idx] = 1'b0;
        seg_nx     = seg_dec;
      end
      dp_nx = ~(sh_dp[idx] & visible);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= RST_STATE;
      sh_value   <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
`ifdef MFP_7SEG_LEADING_ZERO_BLANK_EN
      sh_msd     <= '0;
`endif
    end else begin
      cnt   <= slot_end ? '0 : cnt + CW'(1);
      state <= state_nx;
      if (slot_end) idx <= frame_end ? '0 : idx + IW'(1);
      if (frame_end) begin
        sh_value <= value;
        sh_en    <= digit_en;
        sh_dp    <= dp;
`ifdef MFP_7SEG_LEADING_ZERO_BLANK_EN
        sh_msd   <= msd_nx;
`endif
      end
      frame_done <= frame_end;
      seg_n      <= seg_nx;
      dp_n       <= dp_nx;
      an_n       <= an_nx;
    end
  end

endmodule
